// File: rtl/addr_seq_pkg.sv
// Shared constants for the address sequencer and addr_sel: state encoding,
// the idle serial value and the sweep-window formula both blocks must agree on.
package addr_seq_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Serial value that maps every queue in addr_sel to ADDR_MAX.
  localparam logic [6:0] ADDR_IDLE = 7'd127;

  // Final serial number needed by the last queue.
  function automatic int calc_last(input int sweep_base, input int queue_count,
                                   input int queue_size);
    return sweep_base + (queue_count - 1) * queue_size;
  endfunction

endpackage

// File: rtl/addr_seq_ctrl.sv
// Sequencer feeding addr_sel: sweeps addr_serial_num 0..LAST once per tile,
// back-to-back, then idles the serial number while the array drains.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for start, serial parked at ADDR_IDLE
// RUN     | sweeping 0..LAST, one sweep per tile
// DRAIN   | serial parked, counting down the array flush
// DONE    | one-cycle completion pulse
module addr_seq_ctrl
  import addr_seq_pkg::*;
#(
  parameter int ARRAY_SIZE   = 8,
  parameter int QUEUE_COUNT  = (ARRAY_SIZE + 3) / 4,
  parameter int QUEUE_SIZE   = 4,
  parameter int SWEEP_BASE   = 98,
  parameter int DRAIN_CYCLES = 2 * ARRAY_SIZE + 2,
  parameter logic [6:0] ADDR_IDLE = addr_seq_pkg::ADDR_IDLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] num_tiles,
  input  logic       hold,
  output logic [6:0] addr_serial_num,
  output logic       acc_clear,
  output logic [7:0] tile_idx,
  output logic       busy,
  output logic       done
);

  localparam int LAST = calc_last(SWEEP_BASE, QUEUE_COUNT, QUEUE_SIZE);
  localparam logic [6:0] LAST_A = 7'(LAST);
  localparam int CW = $clog2(DRAIN_CYCLES) + 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES - 1);

  // ADDR_IDLE must stay outside every queue window.
  if (LAST > 126) begin : g_last_check
    $error("addr_seq_ctrl: LAST exceeds 126, ADDR_IDLE would alias a queue window");
  end

  logic [1:0]    state_q, state_d;
  logic [7:0]    tiles_m1_q;
  logic [CW-1:0] drain_cnt_q;
  logic          sweep_end;
  logic          last_tile;

  assign sweep_end = (addr_serial_num == LAST_A);
  assign last_tile = (tile_idx == tiles_m1_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; hold freezes RUN and DRAIN but never DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (!hold && sweep_end && last_tile) state_d = S_DRAIN;
      S_DRAIN: if (!hold && drain_cnt_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Serial number, tile index, latched tile count and drain counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_serial_num <= ADDR_IDLE;
      tile_idx        <= 8'd0;
      tiles_m1_q      <= 8'd0;
      drain_cnt_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // A tile count of zero runs a single tile.
            tiles_m1_q      <= (num_tiles == 8'd0) ? 8'd0 : num_tiles - 8'd1;
            tile_idx        <= 8'd0;
            addr_serial_num <= 7'd0;
          end
        end
        S_RUN: begin
          if (!hold) begin
            if (!sweep_end) begin
              addr_serial_num <= addr_serial_num + 7'd1;
            end else if (!last_tile) begin
              addr_serial_num <= 7'd0;
              tile_idx        <= tile_idx + 8'd1;
            end else begin
              addr_serial_num <= ADDR_IDLE;
              drain_cnt_q     <= DRAIN_LOAD;
            end
          end
        end
        S_DRAIN: begin
          if (!hold && drain_cnt_q != '0) drain_cnt_q <= drain_cnt_q - CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    acc_clear = (state_q == S_RUN) && (addr_serial_num == 7'd0);
  end

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Bench for addr_seq_ctrl: expected output traces are built per run from the
// sweep/drain/done sequence, and hold cycles simply repeat the current entry.
module tb_addr_seq_ctrl;

  localparam int LAST   = 102;
  localparam int DRAIN  = 18;
  localparam int IDLE_A = 127;
  localparam int MAXCYC = 5000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] num_tiles = 8'd0;
  logic [6:0] addr_serial_num;
  logic       acc_clear;
  logic [7:0] tile_idx;
  logic       busy;
  logic       done;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    int addr;
    int tile;
    int acc;
    int bsy;
    int dn;
  } exp_t;

  exp_t tr[$];

  addr_seq_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_tiles       (num_tiles),
    .hold            (hold),
    .addr_serial_num (addr_serial_num),
    .acc_clear       (acc_clear),
    .tile_idx        (tile_idx),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected outputs for every cycle after the accepting edge, hold-free.
  task automatic build(input int n);
    int t_eff;
    t_eff = (n == 0) ? 1 : n;
    tr.delete();
    for (int t = 0; t < t_eff; t++)
      for (int a = 0; a <= LAST; a++)
        tr.push_back('{a, t, (a == 0) ? 1 : 0, 1, 0});
    for (int d = 0; d < DRAIN; d++)
      tr.push_back('{IDLE_A, t_eff - 1, 0, 1, 0});
    tr.push_back('{IDLE_A, t_eff - 1, 0, 1, 1});
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_addr"}, int'(addr_serial_num), IDLE_A);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_acc"},  int'(acc_clear), 0);
  endtask

  // hold_mode: 0 none, 1 random (hold_pct), 2 directed (5 at addr 50, 4 in drain)
  task automatic run(input int n, input int hold_mode, input int hold_pct,
                     input bit poke_start);
    int idx, holds, cyc, bcyc, t_eff;
    bit h;
    idx = 0; holds = 0; cyc = 0; bcyc = 0;
    t_eff = (n == 0) ? 1 : n;
    build(n);
    @(negedge clk);
    num_tiles = 8'(n);
    start = 1'b1;
    hold = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    num_tiles = 8'($urandom);
    while (idx < tr.size() && cyc < MAXCYC) begin
      chk("addr", int'(addr_serial_num), tr[idx].addr);
      if (tr[idx].addr != IDLE_A) chk("tile", int'(tile_idx), tr[idx].tile);
      chk("acc_clear", int'(acc_clear), tr[idx].acc);
      chk("busy", int'(busy), tr[idx].bsy);
      chk("done", int'(done), tr[idx].dn);
      if (busy) bcyc++;
      if (tr[idx].dn == 1)
        h = ($urandom_range(0, 1) == 1);
      else if (hold_mode == 1)
        h = ($urandom_range(0, 99) < hold_pct);
      else if (hold_mode == 2)
        h = (tr[idx].addr == 50 && holds < 5) ||
            (tr[idx].addr == IDLE_A && holds >= 5 && holds < 9);
      else
        h = 1'b0;
      if (h && tr[idx].dn == 0) holds++;
      hold = h;
      start = poke_start && (tr[idx].dn == 1 || tr[idx].addr == 40 ||
                             $urandom_range(0, 19) == 0);
      @(posedge clk);
      #1;
      if (tr[idx].dn == 1 || !h) idx++;
      cyc++;
    end
    chk("timeout", (cyc < MAXCYC) ? 1 : 0, 1);
    check_idle("post_done");
    hold = 1'b0;
    start = 1'b0;
    if (hold_mode == 2) chk("directed_holds", holds, 9);
    chk("busy_len", bcyc, t_eff * (LAST + 1) + DRAIN + 1 + holds);
  endtask

  task automatic reset_mid_run();
    int cyc, dn_seen;
    bit found;
    cyc = 0; dn_seen = 0; found = 1'b0;
    @(negedge clk);
    num_tiles = 8'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    while (!found && cyc < MAXCYC) begin
      if (addr_serial_num == 7'd70 && tile_idx == 8'd1) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cyc++;
      end
    end
    chk("rst_reach_70", found ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    chk("async_rst_tile", int'(tile_idx), 0);
    repeat (3) begin
      @(posedge clk); #1;
      if (done) dn_seen++;
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (DRAIN + 5) begin
      @(posedge clk); #1;
      if (done) dn_seen++;
    end
    chk("rst_no_done", dn_seen, 0);
    check_idle("after_rst");
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    check_idle("reset");
    chk("reset_tile", int'(tile_idx), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check_idle("idle");

    run(1, 0, 0, 1'b0);
    run(3, 0, 0, 1'b0);
    run(1, 2, 0, 1'b0);
    run(2, 0, 0, 1'b1);
    run(1, 0, 0, 1'b0);
    run(0, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++)
      run($urandom_range(0, 4), 1, 20, 1'b1);
    reset_mid_run();
    run(1, 1, 10, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/addr_seq_ctrl.md
# addr_seq_ctrl

Sequencer directly upstream of `addr_sel`. On a start pulse it generates the `addr_serial_num` stream that `addr_sel` skews into per-queue SRAM read addresses, then drains the systolic pipeline.
- Repeats the sweep for a configurable number of tiles, back-to-back with no bubbles.
- Supports a downstream stall.
- Reports busy/done status to the top-level controller.

## Interface

Parameters:
- `ARRAY_SIZE`, 8: systolic array dimension.
- `QUEUE_COUNT`, (ARRAY_SIZE+3)/4: number of address queues in `addr_sel`.
- `QUEUE_SIZE`, 4: per-queue skew step.
- `SWEEP_BASE`, 98: last serial number served by queue 0.
- `DRAIN_CYCLES`, 2*ARRAY_SIZE+2: idle cycles after the final sweep, for array flush.
- `ADDR_IDLE`, 127: serial value that maps every queue to `ADDR_MAX`.

Ports:
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: single-cycle request. Sampled only in IDLE.
- `num_tiles`  in  8: tile count. Latched on accepted `start`. A value of 0 is treated as 1.
- `hold`  in  1: downstream stall. Freezes all counters while high.
- `addr_serial_num`  out  7: registered serial number to `addr_sel`.
- `acc_clear`  out  1: high while `addr_serial_num`==0 in RUN (first sweep step of each tile).
- `tile_idx`  out  8: registered index of the current tile, starting at 0.
- `busy`  out  1: high in RUN, DRAIN and DONE.
- `done`  out  1: one-cycle pulse in DONE.

## Operation

Derived constant: `LAST = SWEEP_BASE + (QUEUE_COUNT-1)*QUEUE_SIZE`, the final serial value needed by the last queue.
- Elaboration check: LAST must be ≤ 126, so that `ADDR_IDLE` stays out of every queue window.
- Default parameters give LAST = 102.

States and transitions:
- **IDLE**
  - `addr_serial_num` = `ADDR_IDLE`.
  - On `start`: latch `max(num_tiles,1)`, clear `tile_idx`, set addr = 0, go to RUN.
- **RUN**, each cycle with `hold`=0:
  - addr < LAST: addr increments by 1.
  - addr == LAST and `tile_idx` < tiles−1: addr = 0, `tile_idx`+1, stay in RUN (no gap).
  - addr == LAST and `tile_idx` == tiles−1: addr = `ADDR_IDLE`, load drain counter with `DRAIN_CYCLES`−1, go to DRAIN.
- **DRAIN**
  - addr stays `ADDR_IDLE`.
  - Counter decrements on each cycle with `hold`=0.
  - At 0 with `hold`=0: go to DONE.
- **DONE**
  - `done`=1 for exactly one cycle, independent of `hold`.
  - Then go to IDLE.
  - `busy` drops on entry to IDLE.

Rules:
- `hold` freezes state, addr, `tile_idx` and the drain counter in RUN and DRAIN.
- `acc_clear` remains high while held at addr 0. Consumers qualify it with !`hold`.
- `start` outside IDLE is ignored. `num_tiles` changes after acceptance have no effect.
- `start` in the same cycle as DONE→IDLE is ignored. A new start is accepted from the first IDLE cycle.
- Serial arithmetic is 7-bit unsigned and never wraps: the 0..LAST range is guaranteed by the elaboration check.

## Timing

Reset values (asynchronous, immediate):
- state = IDLE.
- `addr_serial_num` = 127.
- `tile_idx` = 0.
- `acc_clear`, `busy`, `done` = 0.
- Drain counter = 0.

Reset mid-operation aborts the sequence with no `done` pulse.

Cycle timing with `start` sampled at edge E0 and no `hold`:
- From E0: addr = 0, `busy` = 1, `acc_clear` = 1.
- E0+k: addr = k mod (LAST+1).
- E0+T·(LAST+1): DRAIN, where T = tiles.
- DONE occupies the cycle after E0+T·(LAST+1)+DRAIN_CYCLES.
- IDLE from the following edge.

Totals:
- Busy length = T·(LAST+1) + DRAIN_CYCLES + 1 cycles.
- Each `hold` cycle in RUN or DRAIN adds exactly one cycle.
- `addr_sel` registers once more, so SRAM addresses trail `addr_serial_num` by 1 cycle.

## Structure

- Shared package `addr_seq_pkg`:
  - state encoding localparams `S_IDLE`/`S_RUN`/`S_DRAIN`/`S_DONE` (2 bits);
  - `ADDR_IDLE`;
  - the `LAST` formula, so that `addr_sel` and this block agree on the sweep window.
- Single module, no sub-module. The drain counter is inline and `$clog2(DRAIN_CYCLES)`+1 bits wide.

## Test plan

1. Reset, `start` with `num_tiles`=1 and defaults → addr 0..102 on consecutive cycles, then 127 for 18 cycles, then `done` one cycle; `busy` high for 122 cycles.
2. `num_tiles`=3 → three back-to-back sweeps with 102→0 and no gap; `tile_idx` 0,1,2; `acc_clear` high exactly 3 cycles; busy = 3·103+19 = 328 cycles.
3. `hold` high for 5 cycles at addr 50 and 4 cycles in DRAIN → addr frozen at 50 while held; `done` delayed by exactly 9 cycles versus scenario 1.
4. `start` pulsed at addr 40 and during DONE → ignored; `tile_idx`/addr unaffected; second start accepted in the first IDLE cycle.
5. `rst` asserted at addr 70, tile 1 → outputs reach reset values asynchronously (addr 127, `busy` 0); no `done` pulse.
6. `num_tiles`=0 → behaves identically to `num_tiles`=1 (same cycle count and addr trace).
